// File: rtl/ms_ftdi_phy_pkg.sv
// Shared FSM encoding and default timing constants for the FT245 debug PHY.
package ms_ftdi_phy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_LOW   = 3'd1,
    ST_RD_GAP   = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_LOW   = 3'd4,
    ST_WR_GAP   = 3'd5,
    ST_SIWU     = 3'd6
  } phy_state_t;

  localparam int DEF_RD_LOW_LEN   = 4;
  localparam int DEF_RD_GAP_LEN   = 3;
  localparam int DEF_WR_SETUP_LEN = 1;
  localparam int DEF_WR_LOW_LEN   = 3;
  localparam int DEF_WR_GAP_LEN   = 3;
  localparam int DEF_SIWU_LEN     = 4;
  localparam int DEF_FIFO_LOG     = 2;
  localparam int DEF_LED_HOLD_MS  = 32;

  localparam int TIMER_W = 8;

  // Timer value on the final cycle of a phase lasting len cycles.
  function automatic logic [TIMER_W-1:0] len_to_last(input int len);
    return TIMER_W'(len - 1);
  endfunction

endpackage

// File: rtl/ms_ftdi_phy_fifo.sv
// Small synchronous FIFO with clock enable; head is visible combinationally.
module ms_ftdi_phy_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 1 << LOG;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG:0]     wr_ptr;
  logic [LOG:0]     rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the addresses match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[LOG] != rd_ptr[LOG]) && (wr_ptr[LOG-1:0] == rd_ptr[LOG-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[LOG-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (en) begin
      if (do_push) wr_ptr <= wr_ptr + (LOG+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (LOG+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en && do_push) mem[wr_ptr[LOG-1:0]] <= push_data;
  end

endmodule

// File: rtl/ms_ftdi_phy.sv
// FT245 asynchronous FIFO-mode PHY: RD#/WR#/SIWU# sequencing with rx/tx byte buffers.
module ms_ftdi_phy
  import ms_ftdi_phy_pkg::*;
#(
  parameter int CRdLowLen   = DEF_RD_LOW_LEN,
  parameter int CRdGapLen   = DEF_RD_GAP_LEN,
  parameter int CWrSetupLen = DEF_WR_SETUP_LEN,
  parameter int CWrLowLen   = DEF_WR_LOW_LEN,
  parameter int CWrGapLen   = DEF_WR_GAP_LEN,
  parameter int CSiwuLen    = DEF_SIWU_LEN,
  parameter int CFifoLog    = DEF_FIFO_LOG,
  parameter int CLedHoldMs  = DEF_LED_HOLD_MS
) (
  input  logic       AClkH,
  input  logic       AResetH,
  input  logic       AClkHEn,
  input  logic [7:0] ADbgDataI,
  output logic [7:0] ADbgDataO,
  output logic       ADbgDataOE,
  input  logic       ADbgRF,
  input  logic       ADbgTE,
  output logic       ADbgRd,
  output logic       ADbgWr,
  output logic       ADbgSiwu,
  output logic [1:0] ADbgLed,
  input  logic       ASync1K,
  output logic [7:0] ARxData,
  output logic       ARxValid,
  input  logic       ARxReady,
  input  logic [7:0] ATxData,
  input  logic       ATxValid,
  output logic       ATxReady,
  input  logic       ASendNow
);

  localparam int LED_W = $clog2(CLedHoldMs + 1);

  // User side: a byte moves on valid && ready; both are forced low during reset.
  phy_state_t         state;
  phy_state_t         next_state;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] last_cnt;
  logic               last;
  logic               rf_meta, rf_s, te_meta, te_s;
  logic               rd_ok, wr_ok;
  logic               flush_pend;
  logic               rr_wr_prio;
  logic               rx_empty, rx_full, tx_empty, tx_full;
  logic               rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0]         tx_head;
  logic [7:0]         data_o;
  logic [LED_W-1:0]   led_rx, led_tx;

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      rf_meta <= 1'b1;
      rf_s    <= 1'b1;
      te_meta <= 1'b1;
      te_s    <= 1'b1;
    end else if (AClkHEn) begin
      rf_meta <= ADbgRF;
      rf_s    <= rf_meta;
      te_meta <= ADbgTE;
      te_s    <= te_meta;
    end
  end

  assign ARxValid = !rx_empty && !AResetH;
  assign ATxReady = !tx_full && !AResetH;
  assign rx_pop   = ARxValid && ARxReady;
  assign tx_push  = ATxValid && ATxReady;
  assign rx_push  = (state == ST_RD_LOW) && last;
  assign tx_pop   = (state == ST_IDLE) && (next_state == ST_WR_SETUP);
  assign rd_ok    = !rf_s && !rx_full;
  assign wr_ok    = !te_s && !tx_empty;

  ms_ftdi_phy_fifo #(.WIDTH(8), .LOG(CFifoLog)) u_rx_fifo (
    .clk(AClkH), .rst(AResetH), .en(AClkHEn),
    .push(rx_push), .push_data(ADbgDataI), .pop(rx_pop),
    .head(ARxData), .empty(rx_empty), .full(rx_full)
  );

  ms_ftdi_phy_fifo #(.WIDTH(8), .LOG(CFifoLog)) u_tx_fifo (
    .clk(AClkH), .rst(AResetH), .en(AClkHEn),
    .push(tx_push), .push_data(ATxData), .pop(tx_pop),
    .head(tx_head), .empty(tx_empty), .full(tx_full)
  );

  always_comb begin
    last_cnt = '0;
    case (state)
      ST_RD_LOW:   last_cnt = len_to_last(CRdLowLen);
      ST_RD_GAP:   last_cnt = len_to_last(CRdGapLen);
      ST_WR_SETUP: last_cnt = len_to_last(CWrSetupLen);
      ST_WR_LOW:   last_cnt = len_to_last(CWrLowLen);
      ST_WR_GAP:   last_cnt = len_to_last(CWrGapLen);
      ST_SIWU:     last_cnt = len_to_last(CSiwuLen);
      default:     last_cnt = '0;
    endcase
  end

  assign last = (timer == last_cnt);

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      state <= ST_IDLE;
      timer <= '0;
    end else if (AClkHEn) begin
      state <= next_state;
      timer <= (next_state != state) ? '0 : timer + TIMER_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (rd_ok && wr_ok)  next_state = rr_wr_prio ? ST_WR_SETUP : ST_RD_LOW;
        else if (rd_ok)      next_state = ST_RD_LOW;
        else if (wr_ok)      next_state = ST_WR_SETUP;
        else if (flush_pend) next_state = ST_SIWU;
      end
      ST_RD_LOW:   if (last) next_state = ST_RD_GAP;
      ST_RD_GAP:   if (last) next_state = ST_IDLE;
      ST_WR_SETUP: if (last) next_state = ST_WR_LOW;
      ST_WR_LOW:   if (last) next_state = ST_WR_GAP;
      ST_WR_GAP:   if (last) next_state = ST_IDLE;
      ST_SIWU:     if (last) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ADbgRd     = 1'b1;
    ADbgWr     = 1'b1;
    ADbgSiwu   = 1'b1;
    ADbgDataOE = 1'b0;
    case (state)
      ST_RD_LOW:   ADbgRd = 1'b0;
      ST_WR_SETUP: ADbgDataOE = 1'b1;
      ST_WR_LOW: begin
        ADbgWr     = 1'b0;
        ADbgDataOE = 1'b1;
      end
      ST_WR_GAP:   ADbgDataOE = (timer == '0);
      ST_SIWU:     ADbgSiwu = 1'b0;
      default: ;
    endcase
  end

  assign ADbgDataO = data_o;
  assign ADbgLed   = {led_tx != '0, led_rx != '0};

  // The flush flag drops as SIWU starts so a request arriving during the pulse earns another.
  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      flush_pend <= 1'b0;
      rr_wr_prio <= 1'b0;
      data_o     <= '0;
      led_rx     <= '0;
      led_tx     <= '0;
    end else if (AClkHEn) begin
      if (ASendNow)                                          flush_pend <= 1'b1;
      else if (state == ST_IDLE && next_state == ST_SIWU)    flush_pend <= 1'b0;

      if (tx_pop) begin
        data_o     <= tx_head;
        rr_wr_prio <= 1'b0;
      end else if (state == ST_IDLE && next_state == ST_RD_LOW) begin
        rr_wr_prio <= 1'b1;
      end

      if (rx_push)                      led_rx <= LED_W'(CLedHoldMs);
      else if (ASync1K && led_rx != '0) led_rx <= led_rx - LED_W'(1);

      if (state == ST_WR_LOW && last)   led_tx <= LED_W'(CLedHoldMs);
      else if (ASync1K && led_tx != '0) led_tx <= led_tx - LED_W'(1);
    end
  end

endmodule

// File: tb/tb_ms_ftdi_phy.sv
// Directed bench for ms_ftdi_phy: host pin model, pin-activity monitor and byte scoreboard.
module tb_ms_ftdi_phy;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [7:0] dbg_data_i, dbg_data_o;
  logic       dbg_oe, dbg_rf, dbg_te, dbg_rd, dbg_wr, dbg_siwu;
  logic [1:0] dbg_led;
  logic       sync_1k, send_now;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_ready, tx_valid, tx_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  logic       host_en = 1'b0;
  logic [7:0] host_q[$];
  int         rd_len_q[$], wr_len_q[$], siwu_len_q[$], rd_hi_q[$];
  logic [7:0] acc_log[$], wr_data_q[$], rx_got[$], exp_q[$];
  logic       setup_oe_q[$];
  logic       wr_rise_oe = 1'b0;
  int         rd_run = 0, wr_run = 0, siwu_run = 0, rd_hi_run = 0;
  bit         seen_rd = 1'b0;
  logic       prev_rd = 1'b1, prev_wr = 1'b1, prev_siwu = 1'b1, prev_oe = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  ms_ftdi_phy dut (
    .AClkH(clk), .AResetH(rst), .AClkHEn(en),
    .ADbgDataI(dbg_data_i), .ADbgDataO(dbg_data_o), .ADbgDataOE(dbg_oe),
    .ADbgRF(dbg_rf), .ADbgTE(dbg_te), .ADbgRd(dbg_rd), .ADbgWr(dbg_wr),
    .ADbgSiwu(dbg_siwu), .ADbgLed(dbg_led), .ASync1K(sync_1k),
    .ARxData(rx_data), .ARxValid(rx_valid), .ARxReady(rx_ready),
    .ATxData(tx_data), .ATxValid(tx_valid), .ATxReady(tx_ready),
    .ASendNow(send_now)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin monitor and host model, run just after each falling edge.
  always @(negedge clk) begin
    #1;
    if (!dbg_rd && dbg_oe) viol++;
    if (!dbg_rd && !dbg_wr) viol++;
    if (rx_valid && rx_ready) rx_got.push_back(rx_data);
    if (!dbg_rd) begin
      if (prev_rd) begin
        acc_log.push_back(8'd0);
        if (seen_rd) rd_hi_q.push_back(rd_hi_run);
      end
      rd_run++;
    end else begin
      if (!prev_rd) begin
        rd_len_q.push_back(rd_run);
        rd_run    = 0;
        rd_hi_run = 0;
        seen_rd   = 1'b1;
        if (host_q.size() > 0) void'(host_q.pop_front());
      end
      rd_hi_run++;
    end
    if (!dbg_wr) begin
      if (prev_wr) begin
        acc_log.push_back(8'd1);
        wr_data_q.push_back(prev_data);
        setup_oe_q.push_back(prev_oe);
      end
      wr_run++;
    end else if (!prev_wr) begin
      wr_len_q.push_back(wr_run);
      wr_run     = 0;
      wr_rise_oe = dbg_oe;
    end
    if (!dbg_siwu) siwu_run++;
    else if (!prev_siwu) begin
      siwu_len_q.push_back(siwu_run);
      siwu_run = 0;
    end
    prev_rd    = dbg_rd;
    prev_wr    = dbg_wr;
    prev_siwu  = dbg_siwu;
    prev_oe    = dbg_oe;
    prev_data  = dbg_data_o;
    dbg_rf     = !(host_en && host_q.size() > 0);
    dbg_data_i = (host_q.size() > 0) ? host_q[0] : 8'h00;
  end

  task automatic clear_logs();
    rd_len_q.delete(); wr_len_q.delete(); siwu_len_q.delete(); rd_hi_q.delete();
    acc_log.delete(); wr_data_q.delete(); rx_got.delete(); setup_oe_q.delete();
    rd_run = 0; wr_run = 0; siwu_run = 0; rd_hi_run = 0; seen_rd = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; dbg_te = 1'b1; host_en = 1'b0; host_q.delete();
    rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; send_now = 1'b0; sync_1k = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic push_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_1k();
    @(negedge clk) sync_1k = 1'b1;
    @(negedge clk) sync_1k = 1'b0;
  endtask

  task automatic pulse_send();
    @(negedge clk) send_now = 1'b1;
    @(negedge clk) send_now = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_acc [7];
    exp_acc = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0};
    rst = 1'b1; en = 1'b1; dbg_te = 1'b1; dbg_rf = 1'b1; dbg_data_i = 8'h00;
    rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; send_now = 1'b0; sync_1k = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("reset_tx_ready", tx_ready, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_pins_rd_wr_siwu_oe", {dbg_rd, dbg_wr, dbg_siwu, dbg_oe}, 4'b1110);
    check("reset_data_o", dbg_data_o, 8'h00);
    check("reset_led", dbg_led, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_tx_ready", tx_ready, 1);

    // Single host read of 0x5A
    apply_reset();
    host_q.push_back(8'h5A);
    host_en = 1'b1;
    for (int i = 0; i < 60 && rd_len_q.size() == 0; i++) @(negedge clk);
    check("rx_read_seen", rd_len_q.size(), 1);
    check("rx_rd_low_len", (rd_len_q.size() > 0) ? rd_len_q[0] : 0, 4);
    check("rx_valid", rx_valid, 1);
    check("rx_data", rx_data, 8'h5A);
    check("rx_led", dbg_led, 2'b01);
    repeat (6) @(negedge clk);
    check("rx_single_read", acc_log.size(), 1);
    check("rx_rd_idle_high", dbg_rd, 1);
    repeat (31) pulse_1k();
    check("led_hold_31ms", dbg_led, 2'b01);
    pulse_1k();
    check("led_expire_32ms", dbg_led, 2'b00);
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    check("rx_pop_empty", rx_valid, 0);
    check("rx_popped_byte", (rx_got.size() > 0) ? rx_got[0] : 8'h00, 8'h5A);

    // Single write of 0xA5
    apply_reset();
    dbg_te = 1'b0;
    repeat (3) @(negedge clk);
    push_tx(8'hA5);
    for (int i = 0; i < 60 && wr_len_q.size() == 0; i++) @(negedge clk);
    check("tx_write_seen", wr_len_q.size(), 1);
    check("tx_wr_low_len", (wr_len_q.size() > 0) ? wr_len_q[0] : 0, 3);
    check("tx_setup_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 8'h00, 8'hA5);
    check("tx_setup_oe", (setup_oe_q.size() > 0) ? setup_oe_q[0] : 1'b0, 1);
    check("tx_gap_first_oe", wr_rise_oe, 1);
    check("tx_gap_oe_off", dbg_oe, 0);
    check("tx_led", dbg_led, 2'b10);

    // Fairness: 3 tx bytes queued, 4 host bytes, both sides ready together
    apply_reset();
    rx_ready = 1'b1;
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
    for (int i = 0; i < 4; i++) begin
      host_q.push_back(8'hA1 + 8'(i));
      exp_q.push_back(8'hA1 + 8'(i));
    end
    host_en = 1'b1;
    dbg_te  = 1'b0;
    for (int i = 0; i < 300 && (rx_got.size() < 4 || wr_len_q.size() < 3); i++) @(negedge clk);
    check("fair_access_count", acc_log.size(), 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("fair_order_%0d", i), (acc_log.size() > i) ? acc_log[i] : 8'hFF, exp_acc[i]);
    check("fair_wr_data_0", (wr_data_q.size() > 0) ? wr_data_q[0] : 8'h00, 8'h11);
    check("fair_wr_data_1", (wr_data_q.size() > 1) ? wr_data_q[1] : 8'h00, 8'h22);
    check("fair_wr_data_2", (wr_data_q.size() > 2) ? wr_data_q[2] : 8'h00, 8'h33);
    for (int i = 0; i < 4; i++)
      check($sformatf("fair_rx_%0d", i), (rx_got.size() > i) ? rx_got[i] : 8'h00, exp_q.pop_front());

    // Backpressure: 6 host bytes, consumer stalled
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      host_q.push_back(8'h60 + 8'(i));
      exp_q.push_back(8'h60 + 8'(i));
    end
    host_en = 1'b1;
    repeat (150) @(negedge clk);
    check("bp_reads_when_full", rd_len_q.size(), 4);
    check("bp_host_left", host_q.size(), 2);
    check("bp_rd_idle", dbg_rd, 1);
    check("bp_rd_high_between", (rd_hi_q.size() > 0) ? rd_hi_q[0] : 0, 4);
    check("bp_head", rx_data, 8'h60);
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    for (int i = 0; i < 40 && rd_len_q.size() < 5; i++) @(negedge clk);
    check("bp_fifth_read", rd_len_q.size(), 5);
    rx_ready = 1'b1;
    for (int i = 0; i < 200 && rx_got.size() < 6; i++) @(negedge clk);
    check("bp_rx_count", rx_got.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("bp_rx_%0d", i), (rx_got.size() > i) ? rx_got[i] : 8'h00, exp_q.pop_front());

    // Flush: one pulse, then a repeat request during SIWU
    apply_reset();
    pulse_send();
    for (int i = 0; i < 40 && siwu_len_q.size() == 0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("flush_single_pulse", siwu_len_q.size(), 1);
    check("flush_len", (siwu_len_q.size() > 0) ? siwu_len_q[0] : 0, 4);
    check("flush_no_access", acc_log.size(), 0);
    pulse_send();
    for (int i = 0; i < 20 && dbg_siwu; i++) @(negedge clk);
    check("flush2_started", dbg_siwu, 0);
    pulse_send();
    for (int i = 0; i < 40 && siwu_len_q.size() < 3; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("flush_total_pulses", siwu_len_q.size(), 3);
    check("flush2_len", (siwu_len_q.size() > 1) ? siwu_len_q[1] : 0, 4);
    check("flush3_len", (siwu_len_q.size() > 2) ? siwu_len_q[2] : 0, 4);

    // Reset during WR_LOW with bytes in both buffers
    apply_reset();
    host_q.push_back(8'h42);
    host_en = 1'b1;
    for (int i = 0; i < 60 && rd_len_q.size() == 0; i++) @(negedge clk);
    push_tx(8'h3C);
    push_tx(8'h77);
    check("mid_rx_loaded", rx_valid, 1);
    dbg_te = 1'b0;
    for (int i = 0; i < 40 && dbg_wr; i++) @(negedge clk);
    check("mid_wr_low", dbg_wr, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_wr_release", dbg_wr, 1);
    check("mid_reset_oe_off", dbg_oe, 0);
    check("mid_reset_rd_high", dbg_rd, 1);
    check("mid_reset_tx_ready", tx_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rx_empty", rx_valid, 0);
    check("mid_tx_ready", tx_ready, 1);
    clear_logs();
    repeat (20) @(negedge clk);
    check("mid_no_stale_write", acc_log.size(), 0);
    dbg_te = 1'b1;

    // Clock enable low for 3 cycles stretches RD# low from 4 to 7 cycles
    apply_reset();
    host_q.push_back(8'h99);
    host_en = 1'b1;
    for (int i = 0; i < 40 && dbg_rd; i++) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 40 && rd_len_q.size() == 0; i++) @(negedge clk);
    check("freeze_rd_low_len", (rd_len_q.size() > 0) ? rd_len_q[0] : 0, 7);
    check("freeze_rx_data", rx_data, 8'h99);

    check("no_rd_oe_wr_overlap", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ms_ftdi_phy.md
MS_FTDI_PHY -- requirements
Module: MsFtdiPhy

Interface
REQ-001 SHALL have parameters: CRdLowLen, default 4, RD# low cycles; CRdGapLen, default 3, min 3, RD# high cycles after a read; CWrSetupLen, default 1, data-valid cycles before WR# falls; CWrLowLen, default 3, WR# low cycles; CWrGapLen, default 3, min 3, WR# high cycles after a write; CSiwuLen, default 4, SIWU# low cycles; CFifoLog, default 2, log2 of rx/tx buffer depth; CLedHoldMs, default 32, LED stretch in ms.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with these ports:
- AClkH  in  1  clock
- AResetH  in  1  synchronous active-high reset
- AClkHEn  in  1  clock enable; all state advances only when 1
- ADbgDataI  in  8  FT245 data bus, read direction
- ADbgDataO  out  8  FT245 data bus, write direction
- ADbgDataOE  out  1  bus output enable
- ADbgRF  in  1  RXF#, async; low = host byte available
- ADbgTE  in  1  TXE#, async; low = space available
- ADbgRd  out  1  RD#, active low
- ADbgWr  out  1  WR#, active low
- ADbgSiwu  out  1  SIWU#, active low
- ADbgLed  out  2  [0] rx activity, [1] tx activity
- ASync1K  in  1  1 kHz single-cycle strobe
- ARxData  out  8  received byte
- ARxValid  out  1  rx handshake valid
- ARxReady  in  1  rx handshake ready
- ATxData  in  8  byte to send
- ATxValid  in  1  tx handshake valid
- ATxReady  out  1  tx handshake ready
- ASendNow  in  1  flush request, single-cycle pulse

Function
REQ-003 SHALL pass ADbgRF and ADbgTE through 2-flop synchronizers; the FSM SHALL use only the synchronized values (RfS, TeS).
REQ-004 SHALL contain an rx FIFO and a tx FIFO, each 2^CFifoLog entries, with pointers one bit wider than the address and wrap-around at the depth.
REQ-005 SHALL transfer a rx byte on ARxValid&ARxReady and a tx byte on ATxValid&ATxReady, each in a single cycle.
REQ-006 SHALL drive ARxValid = rx FIFO non-empty and ATxReady = tx FIFO not full; both SHALL be 0 while AResetH is high.
REQ-007 SHALL implement the FSM states IDLE, RD_LOW, RD_GAP, WR_SETUP, WR_LOW, WR_GAP and SIWU.
REQ-008 SHALL qualify a read in IDLE as RdOk = !RfS & rx FIFO not full, and a write as WrOk = !TeS & tx FIFO non-empty.
REQ-009 SHALL arbitrate in IDLE as follows:
- both RdOk and WrOk: round-robin, last-served loses
- only RdOk: go to RD_LOW
- only WrOk: go to WR_SETUP
- otherwise, with a pending flush: go to SIWU
REQ-010 SHALL hold ADbgRd=0 in RD_LOW for CRdLowLen cycles, sample ADbgDataI into the rx FIFO on the last RD_LOW cycle, then hold ADbgRd=1 in RD_GAP for CRdGapLen cycles before returning to IDLE.
REQ-011 SHALL perform a write as follows:
- WR_SETUP: pop the tx FIFO head into ADbgDataO, assert ADbgDataOE, hold ADbgWr=1 for CWrSetupLen cycles
- WR_LOW: hold ADbgWr=0 for CWrLowLen cycles
- WR_GAP: hold ADbgWr=1 with ADbgDataOE still 1 on its first cycle, then 0, for CWrGapLen cycles, then return to IDLE
REQ-012 SHALL latch ASendNow into a pending flag; SIWU SHALL drive ADbgSiwu=0 for CSiwuLen cycles, clear the flag and return to IDLE. An ASendNow arriving during SIWU SHALL re-set the flag.
REQ-013 SHALL treat a simultaneous FIFO push and pop in one cycle as legal, leaving the count unchanged.
REQ-014 SHALL never assert ADbgRd=0 and ADbgDataOE=1 in the same cycle, and never assert ADbgRd=0 and ADbgWr=0 in the same cycle.
REQ-015 SHALL set a per-direction LED counter to CLedHoldMs on each pin-level transfer and decrement it on ASync1K down to a floor of 0; ADbgLed[n] = counter != 0.
REQ-016 SHALL freeze the FSM, timers, FIFOs and LED counters when AClkHEn=0, with pins held at their current levels.

Reset
REQ-017 SHALL on reset drive ADbgRd=1, ADbgWr=1, ADbgSiwu=1, ADbgDataOE=0, ADbgDataO=0 and ADbgLed=0, empty both FIFOs, clear the flush flag and round-robin state, enter IDLE, and set the synchronizers to 1.
REQ-018 SHALL, on reset asserted mid-access, release RD#/WR#/OE on the next edge and drop any partial byte.

Structure
REQ-019 SHALL keep the FSM state encoding and the default timing constants in the shared package MsDbgPkg.
REQ-020 SHALL instantiate a sub-module MsDbgFifo (parameterized width/depth, synchronous reset, clock enable) twice, for rx and tx.

Verification
REQ-021 SHALL verify rx: host model presents 0x5A, RF low -> RD# low 4 cycles, ARxData=0x5A with ARxValid=1 after the read, RD# high 3 cycles.
REQ-022 SHALL verify tx: push 0xA5 with TE low -> DataO=0xA5 and OE=1 one cycle before WR# falls, WR# low 3 cycles.
REQ-023 SHALL verify fairness: RF and TE both low, tx FIFO holding 3 bytes -> accesses alternate RD,WR,RD,WR.
REQ-024 SHALL verify backpressure: ARxReady=0 with host sending 6 bytes -> exactly 4 reads; RD# idle until a pop, then a 5th read.
REQ-025 SHALL verify flush: ASendNow with both FIFOs idle -> SIWU# low 4 cycles exactly once; a second ASendNow during SIWU gives a second pulse.
REQ-026 SHALL verify reset mid-WR_LOW -> WR#=1, OE=0 next cycle, both FIFOs empty, ATxReady=1 after reset release.
